// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Instruction fetch / execute sequencer for a small multi-cycle core.
//   Fetches a 16-bit instruction word from instruction memory at the current
//   program counter, then walks the control unit through four execution
//   steps (step 0..3). At step 3 the control unit may update the PC, either
//   by incrementing it or by loading a branch target.
//
//   Optional feature (macro FETCH_SEQUENCER_HALT_EN):
//     When defined, an instruction whose opcode bits [15:13] are 3'b011
//     completes its four execution steps without touching the PC and then
//     parks the sequencer in HALT until reset. When undefined, that opcode
//     is an ordinary instruction and 'halted' is tied low.
//
// Ports:
//   clock      in   sole clock, rising edge
//   resetn     in   synchronous active-low reset
//   run        in   level enable, sampled in IDLE and at step 3
//   imem_req   out  instruction-memory read request (high in FETCH)
//   imem_addr  out  instruction-memory read address (current PC)
//   imem_ack   in   memory response, imem_data valid the same cycle
//   imem_data  in   fetched instruction word
//   instrucao  out  instruction register for the control unit
//   step       out  execution step counter for the control unit
//   pc_enable  in   PC-update request, honoured only at step 3
//   pc_load    in   1 = load pc_target, 0 = increment
//   pc_target  in   branch target from the datapath
//   pc         out  current program counter
//   busy       out  high in FETCH and EXEC
//   halted     out  high in HALT
// ----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [15:0]     instrucao,
    output logic [1:0]      step,
    input  logic            pc_enable,
    input  logic            pc_load,
    input  logic [PC_W-1:0] pc_target,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [15:0]       r_instr;
    logic [1:0]        r_step;

    logic [PC_W-1:0]   w_pc_next;
    logic              w_halt_op;

    // Candidate PC for the step-3 edge; the increment wraps naturally at
    // the register width.
    always_comb begin
        w_pc_next = r_pc;
        if (pc_enable) begin
            if (pc_load) begin
                w_pc_next = pc_target;
            end else begin
                w_pc_next = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef FETCH_SEQUENCER_HALT_EN
    assign w_halt_op = (r_instr[15:13] == 3'b011);
`else
    assign w_halt_op = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_instr <= '0;
            r_step  <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_step <= 2'd0;
                    if (run) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_step <= 2'd0;
                    // Only an ack seen while requesting captures the word.
                    if (imem_ack) begin
                        r_instr <= imem_data;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_step != 2'd3) begin
                        r_step <= r_step + 2'd1;
                    end else begin
                        r_step <= 2'd0;
                        if (w_halt_op) begin
                            // Halting instruction leaves the PC pointing at itself.
                            r_state <= S_HALT;
                        end else begin
                            r_pc    <= w_pc_next;
                            r_state <= run ? S_FETCH : S_IDLE;
                        end
                    end
                end
                S_HALT: begin
                    r_step <= 2'd0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_step  <= 2'd0;
                end
            endcase
        end
    end

    // Request and address are pure state decodes so they stay stable for
    // as long as the memory takes to answer.
    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign instrucao = r_instr;
    assign step      = r_step;
    assign pc        = r_pc;
    assign busy      = (r_state == S_FETCH) || (r_state == S_EXEC);

`ifdef FETCH_SEQUENCER_HALT_EN
    assign halted    = (r_state == S_HALT);
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Self-checking bench for fetch_sequencer. The bench plays both the
// instruction memory and the control unit. Expected fetch addresses and
// instruction words go into queues as stimulus is set up and are popped
// when the sequencer issues the matching request or enters EXEC.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int PC_W = 8;

    logic            clock;
    logic            resetn;
    logic            run;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_data;
    logic [15:0]     instrucao;
    logic [1:0]      step;
    logic            pc_enable;
    logic            pc_load;
    logic [PC_W-1:0] pc_target;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            halted;

    logic [15:0]     mem [256];
    logic [PC_W-1:0] q_addr [$];
    logic [15:0]     q_instr [$];

    int total = 0;
    int bad   = 0;

    fetch_sequencer #(.PC_W(PC_W)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .run       (run),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .instrucao (instrucao),
        .step      (step),
        .pc_enable (pc_enable),
        .pc_load   (pc_load),
        .pc_target (pc_target),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_reset();
        resetn    = 1'b0;
        run       = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        pc_enable = 1'b0;
        pc_load   = 1'b0;
        pc_target = '0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    // Wait (bounded) for a request and answer it immediately.
    task automatic wait_fetch(output logic [PC_W-1:0] a, output bit got);
        got = 1'b0;
        a   = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            imem_ack = 1'b0;
            if (imem_req) begin
                got       = 1'b1;
                a         = imem_addr;
                imem_ack  = 1'b1;
                imem_data = mem[imem_addr];
            end
        end
    endtask

    // Drive control-unit inputs across the four EXEC steps. Outside step 3
    // pc_enable is held high and pc_load follows ld1 at step 1, so any
    // leakage of those inputs would show as a wrong next fetch address.
    task automatic run_exec(input bit en3, input bit ld3, input logic [PC_W-1:0] tgt,
                            input bit ld1, input bit run3);
        for (int s = 0; s < 4; s++) begin
            @(negedge clock);
            imem_ack  = 1'b0;
            pc_target = tgt;
            pc_enable = (s == 3) ? en3 : 1'b1;
            pc_load   = (s == 3) ? ld3 : ((s == 1) ? ld1 : 1'b0);
            if (s == 3) run = run3;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %h want 00", pc); end
        total++; if (step !== 2'd0) begin bad++; $display("FAIL reset_step: got %0d want 0", step); end
        total++; if (instrucao !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h want 0000", instrucao); end
        total++; if (imem_req !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin
            bad++; $display("FAIL reset_flags: req=%b busy=%b halted=%b want 0/0/0", imem_req, busy, halted);
        end
    endtask

    task automatic test_sequential();
        logic [PC_W-1:0] exp_a;
        logic [15:0]     exp_i;
        int n, last, es;
        do_reset();
        q_addr.push_back(8'h00); q_addr.push_back(8'h01); q_addr.push_back(8'h02);
        run = 1'b1; pc_enable = 1'b1; pc_load = 1'b0;
        n = 0; last = -1; es = 0; exp_i = 16'h0000;
        for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
            @(negedge clock);
            imem_ack = 1'b0;
            if (imem_req) begin
                exp_a = q_addr.pop_front();
                total++; if (imem_addr !== exp_a) begin bad++; $display("FAIL seq_addr: got %h want %h", imem_addr, exp_a); end
                if (last >= 0) begin
                    total++; if (cyc - last != 5) begin bad++; $display("FAIL seq_period: got %0d want 5", cyc - last); end
                end
                last = cyc;
                imem_ack  = 1'b1;
                imem_data = mem[imem_addr];
                q_instr.push_back(mem[exp_a]);
                es = 0;
                n++;
            end else if (busy) begin
                if (es == 0) exp_i = q_instr.pop_front();
                total++; if (step !== es[1:0]) begin bad++; $display("FAIL seq_step: got %0d want %0d", step, es); end
                total++; if (instrucao !== exp_i) begin bad++; $display("FAIL seq_instr: got %h want %h", instrucao, exp_i); end
                es++;
            end
        end
        total++; if (n != 3) begin bad++; $display("FAIL seq_count: got %0d fetches want 3", n); end
        q_instr.delete();
        imem_ack = 1'b0;
    endtask

    task automatic test_ack_delay();
        bit got;
        logic [15:0] exp_i;
        do_reset();
        mem[0] = 16'hABCD;
        run = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (imem_req) got = 1'b1;
        end
        total++; if (!got) begin bad++; $display("FAIL ack_req: got no request want request"); end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clock);
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 8'h00 || step !== 2'd0 || instrucao !== 16'h0000) begin
                bad++;
                $display("FAIL ack_wait: req=%b addr=%h step=%0d instr=%h want 1/00/0/0000",
                         imem_req, imem_addr, step, instrucao);
            end
        end
        imem_ack  = 1'b1;
        imem_data = mem[0];
        q_instr.push_back(16'hABCD);
        @(negedge clock);
        // Keep ack high with junk data: it must be ignored in EXEC.
        imem_data = 16'hFFFF;
        exp_i = q_instr.pop_front();
        total++; if (instrucao !== exp_i || step !== 2'd0 || busy !== 1'b1 || imem_req !== 1'b0) begin
            bad++; $display("FAIL ack_accept: instr=%h step=%0d busy=%b req=%b want %h/0/1/0", instrucao, step, busy, imem_req, exp_i);
        end
        repeat (3) @(negedge clock);
        total++; if (instrucao !== exp_i) begin bad++; $display("FAIL ack_ignored: got %h want %h", instrucao, exp_i); end
        imem_ack = 1'b0;
        mem[0] = 16'h1200;
    endtask

    task automatic test_branch_wrap();
        logic [PC_W-1:0] a, exp_a;
        bit got;
        do_reset();
        run = 1'b1;
        wait_fetch(a, got);
        run_exec(1'b1, 1'b1, 8'h05, 1'b0, 1'b1);
        // pc=5: pc_load only at step 1 must not branch.
        q_addr.push_back(8'h05);
        wait_fetch(a, got); exp_a = q_addr.pop_front();
        total++; if (!got || a !== exp_a) begin bad++; $display("FAIL br_at5: got %h want %h", a, exp_a); end
        run_exec(1'b1, 1'b0, 8'h20, 1'b1, 1'b1);
        q_addr.push_back(8'h06);
        wait_fetch(a, got); exp_a = q_addr.pop_front();
        total++; if (!got || a !== exp_a) begin bad++; $display("FAIL br_ld_step1: got %h want %h", a, exp_a); end
        run_exec(1'b1, 1'b1, 8'h20, 1'b0, 1'b1);
        q_addr.push_back(8'h20);
        wait_fetch(a, got); exp_a = q_addr.pop_front();
        total++; if (!got || a !== exp_a) begin bad++; $display("FAIL br_target: got %h want %h", a, exp_a); end
        total++; if (pc !== 8'h20) begin bad++; $display("FAIL br_pc: got %h want 20", pc); end
        run_exec(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
        q_addr.push_back(8'hFF);
        wait_fetch(a, got); exp_a = q_addr.pop_front();
        total++; if (!got || a !== exp_a) begin bad++; $display("FAIL wrap_ff: got %h want %h", a, exp_a); end
        run_exec(1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
        q_addr.push_back(8'h00);
        wait_fetch(a, got); exp_a = q_addr.pop_front();
        total++; if (!got || a !== exp_a) begin bad++; $display("FAIL wrap_00: got %h want %h", a, exp_a); end
        run_exec(1'b0, 1'b1, 8'h44, 1'b0, 1'b1);
        q_addr.push_back(8'h00);
        wait_fetch(a, got); exp_a = q_addr.pop_front();
        total++; if (!got || a !== exp_a) begin bad++; $display("FAIL hold_refetch: got %h want %h", a, exp_a); end
        imem_ack = 1'b0;
    endtask

    task automatic test_run_drop();
        logic [PC_W-1:0] a;
        bit got;
        do_reset();
        run = 1'b1;
        wait_fetch(a, got);
        @(negedge clock);
        imem_ack = 1'b0;
        run = 1'b0;
        for (int s = 1; s < 4; s++) begin
            pc_enable = 1'b1; pc_load = 1'b0;
            @(negedge clock);
        end
        @(negedge clock);
        total++; if (busy !== 1'b0 || imem_req !== 1'b0 || step !== 2'd0) begin
            bad++; $display("FAIL drop_idle: busy=%b req=%b step=%0d want 0/0/0", busy, imem_req, step);
        end
        total++; if (pc !== 8'h01) begin bad++; $display("FAIL drop_pc: got %h want 01", pc); end
        repeat (3) @(negedge clock);
        total++; if (imem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL drop_stay: req=%b busy=%b want 0/0", imem_req, busy); end
        // Restart and reset while the request is outstanding.
        run = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (imem_req) got = 1'b1;
        end
        total++; if (!got || imem_addr !== 8'h01) begin bad++; $display("FAIL rst_fetch: got req=%b addr=%h want 1/01", got, imem_addr); end
        resetn = 1'b0;
        @(negedge clock);
        total++; if (imem_req !== 1'b0 || pc !== 8'h00) begin bad++; $display("FAIL rst_mid: req=%b pc=%h want 0/00", imem_req, pc); end
        resetn = 1'b1; run = 1'b0;
        imem_ack = 1'b1; imem_data = 16'hBEEF;
        repeat (2) @(negedge clock);
        total++; if (instrucao !== 16'h0000 || busy !== 1'b0) begin
            bad++; $display("FAIL late_ack: instr=%h busy=%b want 0000/0", instrucao, busy);
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_halt_opcode();
        logic [PC_W-1:0] a, exp_a;
        bit got;
        do_reset();
        mem[3] = 16'h6000;
        run = 1'b1;
        wait_fetch(a, got);
        run_exec(1'b1, 1'b1, 8'h03, 1'b0, 1'b1);
        q_addr.push_back(8'h03);
        wait_fetch(a, got); exp_a = q_addr.pop_front();
        total++; if (!got || a !== exp_a) begin bad++; $display("FAIL halt_fetch: got %h want %h", a, exp_a); end
        for (int s = 0; s < 4; s++) begin
            @(negedge clock);
            imem_ack = 1'b0; pc_enable = 1'b1; pc_load = 1'b0;
            total++; if (step !== s[1:0] || busy !== 1'b1) begin
                bad++; $display("FAIL halt_steps: step=%0d busy=%b want %0d/1", step, busy, s);
            end
        end
`ifdef FETCH_SEQUENCER_HALT_EN
        @(negedge clock);
        total++; if (halted !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0 || step !== 2'd0) begin
            bad++; $display("FAIL halt_enter: halted=%b busy=%b req=%b step=%0d want 1/0/0/0", halted, busy, imem_req, step);
        end
        total++; if (pc !== 8'h03) begin bad++; $display("FAIL halt_pc: got %h want 03", pc); end
        repeat (4) @(negedge clock);
        total++; if (halted !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL halt_stay: halted=%b req=%b want 1/0", halted, imem_req); end
`else
        q_addr.push_back(8'h04);
        wait_fetch(a, got); exp_a = q_addr.pop_front();
        total++; if (!got || a !== exp_a) begin bad++; $display("FAIL op011_plain: got %h want %h", a, exp_a); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL op011_halted: got %b want 0", halted); end
`endif
        imem_ack = 1'b0;
        mem[3] = 16'h1203;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'h12, 8'(i)};
        test_reset();
        test_sequential();
        test_ack_delay();
        test_branch_wrap();
        test_run_drop();
        test_halt_opcode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have one parameter: PC_W, default 8, program-counter and instruction-address width in bits.
REQ-002 The block SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port run  in  1  level-sensitive enable to start and continue execution.
REQ-005 The block SHALL have port imem_req  out  1  instruction-memory read request.
REQ-006 The block SHALL have port imem_addr  out  PC_W  instruction-memory read address.
REQ-007 The block SHALL have port imem_ack  in  1  memory response; imem_data valid in the same cycle.
REQ-008 The block SHALL have port imem_data  in  16  fetched instruction word.
REQ-009 The block SHALL have port instrucao  out  16  instruction register, fed to the control unit.
REQ-010 The block SHALL have port step  out  2  execution-step counter, fed to the control unit.
REQ-011 The block SHALL have port pc_enable  in  1  PC-update request from the control unit.
REQ-012 The block SHALL have port pc_load  in  1  1 = load pc_target, 0 = increment.
REQ-013 The block SHALL have port pc_target  in  PC_W  branch target computed by the datapath.
REQ-014 The block SHALL have port pc  out  PC_W  current program counter.
REQ-015 The block SHALL have port busy  out  1  high in FETCH and EXEC states.
REQ-016 The block SHALL have port halted  out  1  high in HALT state.

Function
REQ-017 The block SHALL implement the states IDLE, FETCH, EXEC and HALT.
REQ-018 IDLE SHALL hold imem_req=0 and step=0, and SHALL move to FETCH on the first edge with run=1.
REQ-019 FETCH SHALL drive imem_req=1 and imem_addr=pc combinationally from state, holding both stable until imem_ack=1 is sampled.
REQ-020 On the FETCH edge with imem_ack=1, the block SHALL load instrucao<=imem_data and step<=0 and SHALL move to EXEC.
REQ-021 imem_ack SHALL be ignored outside FETCH.
REQ-022 instrucao SHALL change only on an accepted fetch and SHALL be stable for the entire EXEC state.
REQ-023 In EXEC, step SHALL advance 0->1->2->3, one per cycle.
REQ-024 At step=3, pc SHALL update as follows: pc_enable=1 and pc_load=1 gives pc<=pc_target; pc_enable=1 and pc_load=0 gives pc<=pc+1; pc_enable=0 holds pc.
REQ-025 pc_enable and pc_load SHALL be ignored when step is not 3 or the state is not EXEC.
REQ-026 The pc increment SHALL be modulo 2^PC_W; all-ones+1 SHALL wrap to 0.
REQ-027 Leaving step=3, step SHALL return to 0; the next state SHALL be FETCH if run=1, else IDLE; the PC update SHALL occur either way.
REQ-028 run SHALL be sampled only in IDLE and at step=3; a current instruction SHALL always complete.
REQ-029 step SHALL be 0 in every state other than EXEC.
REQ-030 Minimum instruction period SHALL be 5 cycles: 1 FETCH with immediate ack plus 4 EXEC.
REQ-031 busy SHALL be 1 exactly in FETCH and EXEC; halted SHALL be 1 exactly in HALT.

Reset
REQ-032 On an edge with resetn=0, the block SHALL set state=IDLE, pc=0, instrucao=0 and step=0, giving imem_req=0, busy=0 and halted=0, regardless of current state.
REQ-033 Reset mid-FETCH SHALL abandon the request; a late imem_ack after reset SHALL be ignored.

Configuration
REQ-034 With macro FETCH_SEQUENCER_HALT_EN defined, a fetched word with instrucao[15:13]=3'b011 SHALL complete its 4 EXEC steps without updating pc and SHALL then enter HALT.
REQ-035 HALT SHALL keep step=0, imem_req=0 and halted=1, ignore run, and exit only by reset.
REQ-036 Without FETCH_SEQUENCER_HALT_EN, opcode 3'b011 SHALL be an ordinary instruction under REQ-024, and halted SHALL be tied to 0.

Verification
REQ-037 Reset, run=1, ack immediately on each request, pc_enable=1 and pc_load=0 at step 3: instructions SHALL be fetched from addresses 0,1,2, with 5 cycles per instruction and step sequence 0,1,2,3.
REQ-038 Ack delayed 3 cycles: imem_addr and imem_req SHALL stay stable, step SHALL stay 0, and instrucao SHALL be unchanged until the ack cycle.
REQ-039 pc=5, step 3 with pc_enable=1, pc_load=1, pc_target=8'h20: the next imem_addr SHALL be 8'h20; with pc_load=1 at step 1 only, it SHALL be 6.
REQ-040 pc=8'hFF with increment SHALL give next fetch address 8'h00; pc_enable=0 at step 3 SHALL refetch the same address.
REQ-041 Drop run at step 1: the instruction SHALL finish, pc SHALL update, then IDLE with busy=0; resetn=0 mid-FETCH SHALL drop imem_req on the next edge with pc=0.
REQ-042 With HALT_EN, fetch 16'h6000 at address 3: the block SHALL pass 4 steps, then halted=1 with no further imem_req, and pc SHALL remain 3.
